// File: rtl/row_cache_assoc.sv
// row_cache_assoc
// N-way set-associative row cache for the DDR FSM emulation path. A requested
// DRAM row (RowId) is mapped onto a cache slot cRowId = {set, way}. On a miss
// the requester is stalled with hold until the backing store raises sync, and
// the dirty victim (if any) is reported for writeback. Replacement is true LRU
// using a per-way age that is always a permutation of 0..WAYS-1 within a set.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   RD, WR              level requests held until ack; WR wins over RD
//   RowId               requested row, sampled when the request is accepted
//   sync                backing store finished writeback/fill (used in MISS)
//   hold                miss stall
//   ack, hit            request complete; hit qualifies ack (0 = filled)
//   cRowId              chosen slot {set, way}
//   evict, evictRowId   dirty victim and its row {victim tag, set}
//   hitCnt, missCnt     saturating statistics
module row_cache_assoc #(
  parameter int CHWIDTH   = 5,
  parameter int ADDRWIDTH = 17,
  parameter int WAYBITS   = 2,
  parameter int CNTWIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RD,
  input  logic                 WR,
  input  logic [ADDRWIDTH-1:0] RowId,
  input  logic                 sync,
  output logic                 hold,
  output logic                 ack,
  output logic                 hit,
  output logic [CHWIDTH-1:0]   cRowId,
  output logic                 evict,
  output logic [ADDRWIDTH-1:0] evictRowId,
  output logic [CNTWIDTH-1:0]  hitCnt,
  output logic [CNTWIDTH-1:0]  missCnt
);

  localparam int SETBITS = CHWIDTH - WAYBITS;
  localparam int WAYS    = 1 << WAYBITS;
  localparam int ROWS    = 1 << CHWIDTH;
  localparam int TAGW    = ADDRWIDTH - SETBITS;
  localparam int AGEW    = (WAYBITS > 0) ? WAYBITS : 1;
  localparam logic [ADDRWIDTH-1:0] SETMASK = ADDRWIDTH'((1 << SETBITS) - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, DONE} stateType;

  stateType             state;
  logic [ADDRWIDTH-1:0] reqRow;
  logic                 reqWrite;

  logic                 validBits [ROWS];
  logic                 dirtyBits [ROWS];
  logic [TAGW-1:0]      tags      [ROWS];
  logic [AGEW-1:0]      ages      [ROWS];

  logic [TAGW-1:0]      reqTag;
  logic [CHWIDTH-1:0]   baseSlot;
  logic [CHWIDTH-1:0]   scanSlot;
  logic                 hitFound;
  logic [CHWIDTH-1:0]   hitSlot;
  logic                 invFound;
  logic [CHWIDTH-1:0]   invSlot;
  logic [CHWIDTH-1:0]   lruSlot;
  logic [CHWIDTH-1:0]   victimSlot;
  logic                 doTouch;
  logic [CHWIDTH-1:0]   touchSlot;
  logic [AGEW-1:0]      touchAge;

  // The first slot of a set is the set index shifted up past the way bits,
  // so slot numbers come out as {set, way}.
  assign reqTag   = TAGW'(reqRow >> SETBITS);
  assign baseSlot = CHWIDTH'(reqRow & SETMASK) << WAYBITS;

  // Scan every way of the addressed set at once: find a tag hit, the
  // lowest-index invalid way, and the way carrying the oldest age. An empty
  // way is always preferred as victim so a valid line is never thrown out
  // while space remains in the set.
  always_comb begin
    scanSlot = baseSlot;
    hitFound = 1'b0;
    hitSlot  = baseSlot;
    invFound = 1'b0;
    invSlot  = baseSlot;
    lruSlot  = baseSlot;
    for (int w = 0; w < WAYS; w++) begin
      scanSlot = baseSlot | CHWIDTH'(w);
      if (validBits[scanSlot] && (tags[scanSlot] == reqTag) && !hitFound) begin
        hitFound = 1'b1;
        hitSlot  = scanSlot;
      end
      if (!validBits[scanSlot] && !invFound) begin
        invFound = 1'b1;
        invSlot  = scanSlot;
      end
      if (ages[scanSlot] == AGEW'(WAYS - 1)) begin
        lruSlot = scanSlot;
      end
    end
    victimSlot = invFound ? invSlot : lruSlot;
  end

  // An access that touches the LRU order is either a hit in LOOKUP or the
  // fill completing in MISS; in the latter case the way is the one already
  // registered in cRowId.
  assign doTouch   = ((state == LOOKUP) && hitFound) || ((state == MISS) && sync);
  assign touchSlot = (state == MISS) ? cRowId : hitSlot;
  assign touchAge  = ages[touchSlot];

  // Line storage and per-set ages. Reset invalidates everything and seeds the
  // ages with the way number so each set starts as a valid permutation. On a
  // touch every younger way in the set ages by one and the touched way becomes
  // MRU, which keeps the ages a permutation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        validBits[i] <= 1'b0;
        dirtyBits[i] <= 1'b0;
        tags[i]      <= '0;
        ages[i]      <= AGEW'(i % WAYS);
      end
    end else begin
      if ((state == LOOKUP) && hitFound && reqWrite) begin
        dirtyBits[hitSlot] <= 1'b1;
      end
      if ((state == MISS) && sync) begin
        validBits[cRowId] <= 1'b1;
        dirtyBits[cRowId] <= reqWrite;
        tags[cRowId]      <= reqTag;
      end
      if (doTouch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (ages[baseSlot | CHWIDTH'(w)] < touchAge) begin
            ages[baseSlot | CHWIDTH'(w)] <= ages[baseSlot | CHWIDTH'(w)] + AGEW'(1);
          end
        end
        ages[touchSlot] <= '0;
      end
    end
  end

  // Request sequencing and all registered outputs. The row and operation are
  // captured on accept so later RowId changes cannot disturb the access, and
  // DONE waits for both request lines to drop so a request left high after
  // ack is never looked up twice. Counters stop at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      reqRow     <= '0;
      reqWrite   <= 1'b0;
      hold       <= 1'b0;
      ack        <= 1'b0;
      hit        <= 1'b0;
      cRowId     <= '0;
      evict      <= 1'b0;
      evictRowId <= '0;
      hitCnt     <= '0;
      missCnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (RD || WR) begin
            reqRow   <= RowId;
            reqWrite <= WR;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hitFound) begin
            cRowId <= hitSlot;
            ack    <= 1'b1;
            hit    <= 1'b1;
            if (hitCnt != '1) hitCnt <= hitCnt + CNTWIDTH'(1);
            state  <= DONE;
          end else begin
            cRowId     <= victimSlot;
            evict      <= validBits[victimSlot] & dirtyBits[victimSlot];
            evictRowId <= (ADDRWIDTH'(tags[victimSlot]) << SETBITS) | (reqRow & SETMASK);
            hold       <= 1'b1;
            if (missCnt != '1) missCnt <= missCnt + CNTWIDTH'(1);
            state      <= MISS;
          end
        end
        MISS: begin
          if (sync) begin
            hold       <= 1'b0;
            evict      <= 1'b0;
            evictRowId <= '0;
            ack        <= 1'b1;
            hit        <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          if (!RD && !WR) begin
            ack   <= 1'b0;
            hit   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_cache_assoc.sv
// tb_row_cache_assoc
// Drives row_cache_assoc (default parameters) through the directed scenarios
// and a randomized request stream, comparing against a set/way reference
// model that keeps an explicit recency list per set. A second instance with
// 4-bit counters sees identical stimulus so counter saturation is exercised.
module tb_row_cache_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic        RD;
  logic        WR;
  logic [16:0] RowId;
  logic        sync;

  logic        hold, ack, hit, evict;
  logic [4:0]  cRowId;
  logic [16:0] evictRowId;
  logic [15:0] hitCnt, missCnt;

  logic        satHold, satAck, satHit, satEvict;
  logic [4:0]  satCRowId;
  logic [16:0] satEvictRowId;
  logic [3:0]  satHitCnt, satMissCnt;

  int checks = 0;
  int errors = 0;

  // Reference model: per set, line state per way plus a recency list whose
  // first entry is the most recently used way.
  bit mValid [8][4];
  bit mDirty [8][4];
  int mTag   [8][4];
  int mOrder [8][4];
  int mHits;
  int mMisses;

  int lastSlot;
  bit lastWasHit;
  bit lastEvict;
  int lastEvRow;

  row_cache_assoc dut (
    .clk(clk), .rst(rst), .RD(RD), .WR(WR), .RowId(RowId), .sync(sync),
    .hold(hold), .ack(ack), .hit(hit), .cRowId(cRowId), .evict(evict),
    .evictRowId(evictRowId), .hitCnt(hitCnt), .missCnt(missCnt)
  );

  row_cache_assoc #(.CNTWIDTH(4)) satDut (
    .clk(clk), .rst(rst), .RD(RD), .WR(WR), .RowId(RowId), .sync(sync),
    .hold(satHold), .ack(satAck), .hit(satHit), .cRowId(satCRowId), .evict(satEvict),
    .evictRowId(satEvictRowId), .hitCnt(satHitCnt), .missCnt(satMissCnt)
  );

  // Free-running 10 ns clock.
  initial forever #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 4; w++) begin
        mValid[s][w] = 1'b0;
        mDirty[s][w] = 1'b0;
        mTag[s][w]   = 0;
        mOrder[s][w] = w;
      end
    end
    mHits   = 0;
    mMisses = 0;
  endtask

  // Move a way to the front of its set's recency list.
  task automatic modelTouch(input int s, input int w);
    int p;
    p = 0;
    for (int i = 0; i < 4; i++) if (mOrder[s][i] == w) p = i;
    for (int i = p; i > 0; i--) mOrder[s][i] = mOrder[s][i-1];
    mOrder[s][0] = w;
  endtask

  function automatic int modelFind(input int s, input int tg);
    for (int w = 0; w < 4; w++) if (mValid[s][w] && mTag[s][w] == tg) return w;
    return -1;
  endfunction

  function automatic int modelVictim(input int s);
    for (int w = 0; w < 4; w++) if (!mValid[s][w]) return w;
    return mOrder[s][3];
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // One complete request: accept, decision, optional miss stall until sync,
  // the request held for extraHold more cycles, then release. sync is driven
  // with random noise wherever the cache must ignore it.
  task automatic applyStimulus(input bit rd, input bit wr, input int row,
                               input int syncDelay, input int extraHold);
    int s, tg, w, v, expSlot;
    bit expEvict;
    int expEvRow;
    s  = row & 7;
    tg = row >> 3;
    RD = rd; WR = wr; RowId = 17'(row);
    sync = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    RowId = 17'($urandom);
    checkOutput("lookupAck", {31'd0, ack}, 32'd0);
    checkOutput("lookupHold", {31'd0, hold}, 32'd0);
    @(posedge clk); #1;
    sync = 1'b0;
    w = modelFind(s, tg);
    if (w >= 0) begin
      mHits++;
      expSlot = s * 4 + w;
      if (wr) mDirty[s][w] = 1'b1;
      modelTouch(s, w);
      checkOutput("hitAck", {31'd0, ack}, 32'd1);
      checkOutput("hitHit", {31'd0, hit}, 32'd1);
      checkOutput("hitHold", {31'd0, hold}, 32'd0);
      checkOutput("hitSlot", {27'd0, cRowId}, expSlot);
      lastWasHit = hit;
      lastSlot   = cRowId;
    end else begin
      mMisses++;
      v        = modelVictim(s);
      expSlot  = s * 4 + v;
      expEvict = mValid[s][v] && mDirty[s][v];
      expEvRow = (mTag[s][v] << 3) | s;
      checkOutput("missHold", {31'd0, hold}, 32'd1);
      checkOutput("missAck", {31'd0, ack}, 32'd0);
      checkOutput("missSlot", {27'd0, cRowId}, expSlot);
      checkOutput("missEvict", {31'd0, evict}, {31'd0, expEvict});
      if (expEvict) checkOutput("missEvictRow", {15'd0, evictRowId}, expEvRow);
      lastEvict = evict;
      lastEvRow = evictRowId;
      for (int i = 0; i < syncDelay; i++) begin
        @(posedge clk); #1;
        checkOutput("stallHold", {31'd0, hold}, 32'd1);
      end
      sync = 1'b1;
      @(posedge clk); #1;
      sync = 1'($urandom_range(0, 1));
      mValid[s][v] = 1'b1;
      mDirty[s][v] = wr;
      mTag[s][v]   = tg;
      modelTouch(s, v);
      checkOutput("fillHold", {31'd0, hold}, 32'd0);
      checkOutput("fillAck", {31'd0, ack}, 32'd1);
      checkOutput("fillHit", {31'd0, hit}, 32'd0);
      checkOutput("fillEvict", {31'd0, evict}, 32'd0);
      checkOutput("fillSlot", {27'd0, cRowId}, expSlot);
      lastWasHit = hit;
      lastSlot   = cRowId;
    end
    checkOutput("hitCnt", {16'd0, hitCnt}, sat(mHits, 16'hFFFF));
    checkOutput("missCnt", {16'd0, missCnt}, sat(mMisses, 16'hFFFF));
    checkOutput("satHitCnt", {28'd0, satHitCnt}, sat(mHits, 15));
    checkOutput("satMissCnt", {28'd0, satMissCnt}, sat(mMisses, 15));
    for (int i = 0; i < extraHold; i++) begin
      @(posedge clk); #1;
      checkOutput("heldAck", {31'd0, ack}, 32'd1);
    end
    RD = 1'b0; WR = 1'b0;
    @(posedge clk); #1;
    sync = 1'b0;
    checkOutput("releaseAck", {31'd0, ack}, 32'd0);
    checkOutput("releaseHit", {31'd0, hit}, 32'd0);
    checkOutput("relHitCnt", {16'd0, hitCnt}, sat(mHits, 16'hFFFF));
    checkOutput("relMissCnt", {16'd0, missCnt}, sat(mMisses, 16'hFFFF));
  endtask

  // Directed scenarios first, then a random stream over a small row pool so
  // hits, clean and dirty evictions all occur, then reset during a stall.
  initial begin
    int op;
    bit isMiss;
    rst = 1'b1; RD = 1'b0; WR = 1'b0; sync = 1'b0; RowId = '0;
    modelReset();
    #12;
    checkOutput("rstHold", {31'd0, hold}, 32'd0);
    checkOutput("rstAck", {31'd0, ack}, 32'd0);
    checkOutput("rstHit", {31'd0, hit}, 32'd0);
    checkOutput("rstEvict", {31'd0, evict}, 32'd0);
    checkOutput("rstSlot", {27'd0, cRowId}, 32'd0);
    checkOutput("rstEvictRow", {15'd0, evictRowId}, 32'd0);
    checkOutput("rstHitCnt", {16'd0, hitCnt}, 32'd0);
    checkOutput("rstMissCnt", {16'd0, missCnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(1'b1, 1'b0, 'h13, 3, 0);
    checkOutput("t1Slot", lastSlot, 32'd12);
    checkOutput("t1Hit", {31'd0, lastWasHit}, 32'd0);
    checkOutput("t1Evict", {31'd0, lastEvict}, 32'd0);

    applyStimulus(1'b1, 1'b0, 'h13, 0, 4);
    checkOutput("t2Slot", lastSlot, 32'd12);
    checkOutput("t2Hit", {31'd0, lastWasHit}, 32'd1);

    applyStimulus(1'b0, 1'b1, 'h0B, 1, 0);
    checkOutput("t3SlotA", lastSlot, 32'd13);
    applyStimulus(1'b0, 1'b1, 'h1B, 0, 1);
    checkOutput("t3SlotB", lastSlot, 32'd14);
    applyStimulus(1'b0, 1'b1, 'h23, 2, 0);
    checkOutput("t3SlotC", lastSlot, 32'd15);
    applyStimulus(1'b1, 1'b0, 'h13, 0, 0);
    checkOutput("t3HitWay0", lastSlot, 32'd12);
    applyStimulus(1'b0, 1'b1, 'h2B, 1, 0);
    checkOutput("t3VictimSlot", lastSlot, 32'd13);
    checkOutput("t3VictimEvict", {31'd0, lastEvict}, 32'd1);
    checkOutput("t3VictimRow", lastEvRow, 32'h0B);

    applyStimulus(1'b1, 1'b0, 'h03, 0, 0);
    applyStimulus(1'b1, 1'b0, 'h43, 1, 0);
    applyStimulus(1'b1, 1'b0, 'h83, 0, 0);
    applyStimulus(1'b1, 1'b0, 'hC3, 2, 0);
    applyStimulus(1'b1, 1'b0, 'h103, 0, 0);
    checkOutput("t4CleanEvict", {31'd0, lastEvict}, 32'd0);

    applyStimulus(1'b1, 1'b1, 'h05, 0, 0);
    applyStimulus(1'b1, 1'b0, 'h0D, 0, 0);
    applyStimulus(1'b1, 1'b0, 'h15, 1, 0);
    applyStimulus(1'b1, 1'b0, 'h1D, 0, 0);
    applyStimulus(1'b1, 1'b0, 'h25, 0, 0);
    checkOutput("t5Evict", {31'd0, lastEvict}, 32'd1);
    checkOutput("t5EvictRow", lastEvRow, 32'h05);

    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 2);
      applyStimulus(op != 1, op != 0,
                    ($urandom_range(0, 7) << 3) | $urandom_range(0, 7),
                    $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while a miss is stalled: outputs must fall without a clock edge.
    isMiss = (modelFind(6, 'h1F) < 0);
    RD = 1'b1; RowId = 17'h0FE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("t6HoldBefore", {31'd0, hold}, {31'd0, isMiss});
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6HoldAsync", {31'd0, hold}, 32'd0);
    checkOutput("t6AckAsync", {31'd0, ack}, 32'd0);
    checkOutput("t6HitCntAsync", {16'd0, hitCnt}, 32'd0);
    checkOutput("t6MissCntAsync", {16'd0, missCnt}, 32'd0);
    RD = 1'b0;
    modelReset();
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 'h13, 1, 0);
    checkOutput("t6Slot", lastSlot, 32'd12);
    checkOutput("t6Hit", {31'd0, lastWasHit}, 32'd0);
    checkOutput("t6MissCnt", {16'd0, missCnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_cache_assoc.md
# row_cache_assoc

Parametrised N-way set-associative row cache with true-LRU replacement and dirty tracking. It is the successor of the direct-mapped row cache in the DDR FSM emulation path. It maps a DRAM RowId onto a cache-row slot (cRowId) and stalls the requester with `hold` on a miss until the backing store signals `sync`. It also reports the dirty victim to be written back, and keeps hit/miss statistics.

## Interface
- CHWIDTH, 5: log2 of total cache rows; total rows = 2**CHWIDTH.
- ADDRWIDTH, 17: RowId width.
- WAYBITS, 2: log2 of associativity (WAYS = 2**WAYBITS); must satisfy 0 ≤ WAYBITS ≤ CHWIDTH.
- CNTWIDTH, 16: width of the statistics counters.
- Derived: SETBITS = CHWIDTH−WAYBITS; SETS = 2**SETBITS; tag = RowId[ADDRWIDTH-1:SETBITS]; set = RowId[SETBITS-1:0].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- RD  in  1  read request, level; held by the requester until `ack`.
- WR  in  1  write request, level; WR has priority if both RD and WR are high.
- RowId  in  ADDRWIDTH  requested row, sampled on accept.
- sync  in  1  backing store has completed writeback/fill; sampled only in MISS.
- hold  out  1  miss stall; high from the miss decision until the cycle after sync.
- ack  out  1  request complete; stays high until RD and WR are both low.
- hit  out  1  qualifies `ack`: 1 = hit, 0 = filled after a miss.
- cRowId  out  CHWIDTH  slot {set, way}; valid while hold or ack is high.
- evict  out  1  victim is valid and dirty; valid while hold is high.
- evictRowId  out  ADDRWIDTH  victim row {victim tag, set}; valid when evict is high.
- hitCnt, missCnt  out  CNTWIDTH each  saturating statistics.

## Operation
- State per line: valid, dirty, tag.
- State per set: WAYBITS-bit age for each way. Age 0 is MRU and age WAYS−1 is LRU; the ages in a set are always a permutation of 0..WAYS−1.
- FSM states: IDLE, LOOKUP, MISS, DONE.
- IDLE: if RD|WR, latch RowId and op (write if WR), then go to LOOKUP.
- LOOKUP: compare the latched tag against all valid ways of the set.
  - Hit: register cRowId={set,way}, set ack=1 and hit=1, set dirty if the op is a write, update LRU, increment hitCnt, go to DONE.
  - Miss: pick the victim, which is the lowest-index invalid way, else the way with age WAYS−1. Register cRowId, evict and evictRowId, set hold=1, increment missCnt, go to MISS.
- MISS: wait for sync=1. On that edge:
  - Install the tag, set valid=1 and dirty=op.
  - Update LRU.
  - Clear hold, evict and evictRowId; set ack=1 and hit=0.
  - Go to DONE.
- DONE: hold ack, hit and cRowId. When RD=0 and WR=0, clear ack and hit and go to IDLE. A request held high after ack never starts a second lookup.
- LRU update on access to way w with old age a:
  - Every way in the set with age < a increments.
  - Way w gets age 0.
  - Other sets are untouched.
- Counters saturate at all-ones; they do not wrap.
- With WAYBITS=0 the block behaves as a direct-mapped cache and the victim is always way 0.

## Timing
- Reset values, applied asynchronously:
  - State is IDLE.
  - hold, ack, hit, evict = 0; cRowId = 0; evictRowId = 0; counters = 0.
  - All valid and dirty bits are 0.
  - Age of way w = w in every set.
- Accept at edge t, where IDLE sees RD|WR. The hit/miss decision is visible after edge t+1, so hit latency is 2 cycles.
- Miss: hold rises after edge t+1. If sync is sampled high at edge s, then hold=0 and ack=1 after edge s. sync is ignored outside MISS.
- Release: if RD=WR=0 is sampled at edge r in DONE, ack=0 after edge r. The earliest next accept is edge r+1.
- RowId changes after accept are ignored.
- Reset mid-operation: all outputs drop immediately, contents are invalidated, and any pending miss is abandoned.

## Test plan
Defaults: CHWIDTH=5, ADDRWIDTH=17, WAYBITS=2 (8 sets); set = RowId[2:0].
1. Cold read RowId=0x00013 (set 3), then sync 3 cycles later:
   - hold=1 two cycles after accept, cRowId=12, evict=0.
   - After sync: ack=1, hit=0, missCnt=1.
2. Repeat read 0x00013 with RD held 6 cycles:
   - hit=1 and ack=1 at accept+2, cRowId=12, hold never rises.
   - hitCnt=1; there is no second lookup while RD stays high.
3. Set 3 replacement:
   - WR 0x0000B, 0x0001B, 0x00023 lands in ways 1, 2, 3 (cRowId 13, 14, 15), each with evict=0.
   - Read 0x00013 hits way 0.
   - WR 0x0002B misses with victim way 1: cRowId=13, evict=1, evictRowId=0x0000B.
4. Clean victim:
   - Read 0x00003, 0x00043, 0x00083, 0x000C3 (set 3 is then all clean reads), then read 0x00103.
   - Required response: miss with evict=0 and victim = LRU way.
5. RD=WR=1 on 0x00005: treated as a write. After eviction pressure on set 5, that line reports evict=1.
6. Reset asserted while hold=1: hold drops without waiting for a clock. A subsequent read of 0x00013 misses, with cRowId=12 and counters restarted at 0. Separately, force 2^16+3 hits and check that hitCnt holds 0xFFFF.
